// File: rtl/cmos_gate_sequencer.sv
`timescale 1ns/1ps
// Stimulus/check engine for the CMOS gate bank: it applies LFSR vectors, waits the settle time, then compares the results.
// Optional STOP_ON_FAIL_EN: end the run at the first failing vector.
module cmos_gate_sequencer #(
  parameter int unsigned NUM_VECTORS   = 10,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] seed,
  output logic       stim_in,
  output logic       stim_a,
  output logic       stim_b,
  input  logic       res_inv,
  input  logic       res_nand,
  input  logic       res_nor,
  input  logic       res_xor,
  input  logic       res_xnor,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [4:0] fail_mask,
  output logic [7:0] vec_count
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam logic [7:0] NUM_VEC_L   = 8'(NUM_VECTORS);

  state_t     state;
  state_t     state_next;
  logic [7:0] lfsr;
  logic [3:0] settle_cnt;
  logic [4:0] exp_res;
  logic [4:0] mismatch;
  logic [7:0] vec_next;
  logic       last_vec;
  logic       stop_now;

  assign busy = (state != IDLE);

  // Case-inequality so that X/Z on a gate output counts as a failure.
  always_comb begin
    exp_res     = {~(stim_a ^ stim_b), stim_a ^ stim_b, ~(stim_a | stim_b),
                   ~(stim_a & stim_b), ~stim_in};
    mismatch    = 5'b00000;
    mismatch[0] = (res_inv  !== exp_res[0]);
    mismatch[1] = (res_nand !== exp_res[1]);
    mismatch[2] = (res_nor  !== exp_res[2]);
    mismatch[3] = (res_xor  !== exp_res[3]);
    mismatch[4] = (res_xnor !== exp_res[4]);
    vec_next    = vec_count + 8'd1;
    last_vec    = (vec_next >= NUM_VEC_L);
  end

`ifdef STOP_ON_FAIL_EN
  assign stop_now = |mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = APPLY;
      APPLY:   state_next = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = CHECK;
      CHECK:   state_next = (last_vec || stop_now) ? DONE : APPLY;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Datapath; an abort in a busy state overrides whatever that state would update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= LFSR_SEED;
      settle_cnt <= 4'd0;
      stim_in    <= 1'b0;
      stim_a     <= 1'b0;
      stim_b     <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 8'd0;
      fail_mask  <= 5'b00000;
      vec_count  <= 8'd0;
    end else begin
      done <= 1'b0;
      if (busy && abort) begin
        stim_in <= 1'b0;
        stim_a  <= 1'b0;
        stim_b  <= 1'b0;
        pass    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              lfsr      <= (seed == 8'd0) ? LFSR_SEED : seed;
              err_count <= 8'd0;
              fail_mask <= 5'b00000;
              vec_count <= 8'd0;
              pass      <= 1'b0;
            end
          end
          APPLY: begin
            stim_in    <= lfsr[0];
            stim_a     <= lfsr[1];
            stim_b     <= lfsr[2];
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            settle_cnt <= 4'd0;
          end
          SETTLE: settle_cnt <= settle_cnt + 4'd1;
          CHECK: begin
            fail_mask <= fail_mask | mismatch;
            if ((|mismatch) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            vec_count <= vec_next;
          end
          DONE: begin
            done <= 1'b1;
            pass <= (err_count == 8'd0);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmos_gate_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for cmos_gate_sequencer: table-driven runs against a modelled gate bank, plus abort/reset sequences.
module tb_cmos_gate_sequencer;

  localparam int         NUM_VECTORS   = 10;
  localparam int         SETTLE_CYCLES = 2;
  localparam logic [7:0] LFSR_SEED     = 8'hA5;
  localparam int         RUN_EDGES     = 1 + NUM_VECTORS * (SETTLE_CYCLES + 2);
  localparam int         STOP_EDGES    = 1 + SETTLE_CYCLES + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] seed;
  logic       stim_in, stim_a, stim_b;
  wire        res_inv, res_nand, res_nor, res_xor, res_xnor;
  logic       gate_inv, gate_nand, gate_nor, gate_xor, gate_xnor;
  logic       busy, done, pass;
  logic [7:0] err_count, vec_count;
  logic [4:0] fail_mask;
  int         fault_mode;
  int         total;
  int         bad;
  int         done_pulses;
  logic [7:0] prev_vec = 8'd0;

  typedef struct {
    logic [7:0] seed;
    int         fault;
    int         exp_err;
    logic [4:0] exp_mask;
    logic [4:0] mask_care;
    int         exp_vec;
    logic       exp_pass;
    int         exp_lat;
  } run_t;

  run_t       result_q[$];
  logic [2:0] stim_q[$];

  cmos_gate_sequencer #(
    .NUM_VECTORS(NUM_VECTORS), .SETTLE_CYCLES(SETTLE_CYCLES), .LFSR_SEED(LFSR_SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .stim_in(stim_in), .stim_a(stim_a), .stim_b(stim_b),
    .res_inv(res_inv), .res_nand(res_nand), .res_nor(res_nor),
    .res_xor(res_xor), .res_xnor(res_xnor),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  // Gate bank model: 0 ideal, 1 all outputs floating, 2 xor stuck-at-0, 3 inverter stuck-at-1
  always_comb begin
    gate_inv  = ~stim_in;
    gate_nand = ~(stim_a & stim_b);
    gate_nor  = ~(stim_a | stim_b);
    gate_xor  = stim_a ^ stim_b;
    gate_xnor = ~(stim_a ^ stim_b);
    if (fault_mode == 2) gate_xor = 1'b0;
    if (fault_mode == 3) gate_inv = 1'b1;
  end

  assign res_inv  = (fault_mode == 1) ? 1'bz : gate_inv;
  assign res_nand = (fault_mode == 1) ? 1'bz : gate_nand;
  assign res_nor  = (fault_mode == 1) ? 1'bz : gate_nor;
  assign res_xor  = (fault_mode == 1) ? 1'bz : gate_xor;
  assign res_xnor = (fault_mode == 1) ? 1'bz : gate_xnor;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] eff_seed(input logic [7:0] s);
    return (s == 8'd0) ? LFSR_SEED : s;
  endfunction

  // kind 0: vectors with a^b=1; kind 1: vectors with in=1
  function automatic int count_hits(input logic [7:0] s, input int kind);
    logic [7:0] v;
    int n;
    v = eff_seed(s);
    n = 0;
    for (int i = 0; i < NUM_VECTORS; i++) begin
      if (kind == 0 && (v[1] ^ v[2])) n++;
      if (kind == 1 && v[0]) n++;
      v = lfsr_step(v);
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushStims(input logic [7:0] s, input int n);
    logic [7:0] v;
    v = eff_seed(s);
    for (int i = 0; i < n; i++) begin
      stim_q.push_back({v[2], v[1], v[0]});
      v = lfsr_step(v);
    end
  endtask

  // Each time vec_count advances, the stimulus that was just checked is still on the outputs.
  always @(negedge clk) begin
    if (done) done_pulses++;
    if (rst_n && vec_count != prev_vec && vec_count != 8'd0) begin
      if (stim_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL stim_unexpected: got vector %0d expected none", vec_count);
      end else begin
        checkOutput("stim_vec", {29'd0, stim_b, stim_a, stim_in}, {29'd0, stim_q.pop_front()});
      end
    end
    prev_vec = vec_count;
  end

  task automatic applyStimulus(input run_t r);
    fault_mode = r.fault;
    pushStims(r.seed, r.exp_vec);
    result_q.push_back(r);
    @(negedge clk);
    seed  = r.seed;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int   edges;
    run_t x;
    edges = 0;
    while (done !== 1'b1 && edges < 400) begin
      @(posedge clk);
      #1;
      edges++;
    end
    x = result_q.pop_front();
    checkOutput({name, "_latency"}, edges, x.exp_lat);
    checkOutput({name, "_err"}, err_count, x.exp_err);
    checkOutput({name, "_mask"}, fail_mask & x.mask_care, x.exp_mask & x.mask_care);
    checkOutput({name, "_vec"}, vec_count, x.exp_vec);
    checkOutput({name, "_pass"}, pass, x.exp_pass);
    checkOutput({name, "_busy"}, busy, 0);
    checkOutput({name, "_stim_left"}, stim_q.size(), 0);
    stim_q.delete();
    @(posedge clk);
    #1 checkOutput({name, "_done_width"}, done, 0);
  endtask

  initial begin
    run_t runs[4];
    int   pulses_before;
    total = 0; bad = 0; done_pulses = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = 8'd0; fault_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_pass", pass, 0);
    checkOutput("reset_err", err_count, 0);
    checkOutput("reset_mask", fail_mask, 0);
    checkOutput("reset_vec", vec_count, 0);
    checkOutput("reset_stim", {stim_b, stim_a, stim_in}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runs[0] = '{seed: 8'h01, fault: 0, exp_err: 0, exp_mask: 5'b00000, mask_care: 5'b11111,
                exp_vec: NUM_VECTORS, exp_pass: 1'b1, exp_lat: RUN_EDGES};
`ifdef STOP_ON_FAIL_EN
    runs[1] = '{seed: 8'h00, fault: 1, exp_err: 1, exp_mask: 5'b01010, mask_care: 5'b01010,
                exp_vec: 1, exp_pass: 1'b0, exp_lat: STOP_EDGES};
    runs[2] = '{seed: 8'hA5, fault: 2, exp_err: 1, exp_mask: 5'b01000, mask_care: 5'b11111,
                exp_vec: 1, exp_pass: 1'b0, exp_lat: STOP_EDGES};
    runs[3] = '{seed: 8'h01, fault: 3, exp_err: 1, exp_mask: 5'b00001, mask_care: 5'b11111,
                exp_vec: 1, exp_pass: 1'b0, exp_lat: STOP_EDGES};
`else
    runs[1] = '{seed: 8'h00, fault: 1, exp_err: NUM_VECTORS, exp_mask: 5'b11111, mask_care: 5'b11111,
                exp_vec: NUM_VECTORS, exp_pass: 1'b0, exp_lat: RUN_EDGES};
    runs[2] = '{seed: 8'hA5, fault: 2, exp_err: count_hits(8'hA5, 0), exp_mask: 5'b01000,
                mask_care: 5'b11111, exp_vec: NUM_VECTORS, exp_pass: 1'b0, exp_lat: RUN_EDGES};
    runs[3] = '{seed: 8'h01, fault: 3, exp_err: count_hits(8'h01, 1), exp_mask: 5'b00001,
                mask_care: 5'b11111, exp_vec: NUM_VECTORS, exp_pass: 1'b0, exp_lat: RUN_EDGES};
`endif

    for (int i = 0; i < 4; i++) begin
      applyStimulus(runs[i]);
      waitDone($sformatf("run%0d", i));
    end

    // Abort in vector 3 CHECK; a second start mid-run must be ignored; seed 0 selects LFSR_SEED.
    pulses_before = done_pulses;
    fault_mode = 0;
    pushStims(8'h00, NUM_VECTORS);
    @(negedge clk);
    seed  = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    seed  = 8'h3C;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("abort_busy_during", busy, 1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("abort_vec_before", vec_count, 2);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_vec", vec_count, 2);
    checkOutput("abort_stim", {stim_b, stim_a, stim_in}, 0);
    checkOutput("abort_pass", pass, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_stim_left", stim_q.size(), NUM_VECTORS - 2);
    stim_q.delete();
    repeat (20) @(posedge clk);
    #1 checkOutput("abort_no_done", done_pulses, pulses_before);

    // start and abort together in IDLE: nothing starts, counters keep their values
    @(negedge clk);
    seed  = 8'h01;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 checkOutput("start_abort_vec", vec_count, 2);

    // Asynchronous reset in the middle of vector 3 SETTLE
    pulses_before = done_pulses;
    applyStimulus('{seed: 8'h01, fault: 0, exp_err: 0, exp_mask: 5'b00000, mask_care: 5'b11111,
                    exp_vec: NUM_VECTORS, exp_pass: 1'b1, exp_lat: RUN_EDGES});
    void'(result_q.pop_back());
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rst_vec_before", vec_count, 2);
    checkOutput("rst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_vec", vec_count, 0);
    checkOutput("rst_err", err_count, 0);
    checkOutput("rst_mask", fail_mask, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_stim", {stim_b, stim_a, stim_in}, 0);
    stim_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("rst_no_done", done_pulses, pulses_before);
    checkOutput("rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
